// File: rtl/rtype_exec_sequencer.sv
// Execute-stage sequencer for decoded R-type ops.
// Accepts one op per valid/ready handshake and computes non-shift ops in the
// accept cycle. Shifts run through an iterative shifter that moves at most
// SHIFT_STEP bit positions per cycle. The result is held until writeback
// takes it.

package opcode_type;
  typedef enum logic [3:0] {
    rak_add  = 4'd0,
    rak_sub  = 4'd1,
    rak_sll  = 4'd2,
    rak_slt  = 4'd3,
    rak_sltu = 4'd4,
    rak_xor  = 4'd5,
    rak_srl  = 4'd6,
    rak_sra  = 4'd7,
    rak_or   = 4'd8,
    rak_and  = 4'd9
  } reg_arith_kind_t;
endpackage

module rtype_exec_sequencer
  import opcode_type::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  reg_arith_kind_t in_kind,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  // Step size carries one extra bit so SHIFT_STEP == XLEN is representable.
  localparam logic [SW:0] STEP_C = SHIFT_STEP[SW:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic            in_ready_s;
  logic            busy_s;
  logic            accept_s;
  logic            start_shift_s;
  logic [SW-1:0]   shamt_in_s;
  logic [SW-1:0]   step_s;
  logic            shift_last_s;
  logic [XLEN-1:0] shift_val_s;

  reg_arith_kind_t kind_r;
  logic [XLEN-1:0] work_r;
  logic [SW-1:0]   cnt_r;
  logic            out_valid_r;
  logic [XLEN-1:0] out_result_r;
  logic [4:0]      out_rd_r;

  // Shift helper shared by the single-cycle path and the iterative shifter.
  function automatic logic [XLEN-1:0] shift_fn(input reg_arith_kind_t kind,
                                               input logic [XLEN-1:0] val,
                                               input logic [SW-1:0]   amt);
    logic [XLEN-1:0] res;
    case (kind)
      rak_sll: res = val << amt;
      rak_srl: res = val >> amt;
      rak_sra: res = $signed(val) >>> amt;
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  // Single-cycle ALU; undefined kinds produce zero.
  function automatic logic [XLEN-1:0] alu_fn(input reg_arith_kind_t kind,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    case (kind)
      rak_add:  res = a + b;
      rak_sub:  res = a - b;
      rak_slt:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      rak_sltu: res = {{(XLEN-1){1'b0}}, (a < b)};
      rak_xor:  res = a ^ b;
      rak_or:   res = a | b;
      rak_and:  res = a & b;
      rak_sll,
      rak_srl,
      rak_sra:  res = shift_fn(kind, a, b[SW-1:0]);
      default:  res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  assign shamt_in_s    = in_rs2[SW-1:0];
  assign accept_s      = in_valid && in_ready_s;
  assign start_shift_s = accept_s && (shamt_in_s != {SW{1'b0}}) &&
                         ((in_kind == rak_sll) || (in_kind == rak_srl) || (in_kind == rak_sra));
  assign step_s        = ({1'b0, cnt_r} > STEP_C) ? STEP_C[SW-1:0] : cnt_r;
  assign shift_last_s  = (cnt_r == step_s);
  assign shift_val_s   = shift_fn(kind_r, work_r, step_s);

  // State register; reset returns to IDLE and silently drops any op in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an accept in DONE is handled exactly like one in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_next_s = start_shift_s ? ST_SHIFT : ST_DONE;
        end else if (state_r == ST_IDLE || out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (shift_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Handshake outputs; out_ready reaches in_ready combinationally for back-to-back issue.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    if (rst) begin
      in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
      busy_s     = (state_r != ST_IDLE);
    end else begin
      in_ready_s = 1'b0;
      busy_s     = 1'b0;
    end
  end

  // Operand latch, iterative shifter and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      kind_r       <= rak_add;
      work_r       <= {XLEN{1'b0}};
      cnt_r        <= {SW{1'b0}};
      out_valid_r  <= 1'b0;
      out_result_r <= {XLEN{1'b0}};
      out_rd_r     <= 5'd0;
    end else begin
      if (accept_s) begin
        kind_r   <= in_kind;
        work_r   <= in_rs1;
        out_rd_r <= in_rd;
        if (start_shift_s) begin
          cnt_r <= shamt_in_s;
        end else begin
          cnt_r        <= {SW{1'b0}};
          out_result_r <= alu_fn(in_kind, in_rs1, in_rs2);
        end
      end else if (state_r == ST_SHIFT) begin
        work_r <= shift_val_s;
        cnt_r  <= cnt_r - step_s;
        if (shift_last_s) begin
          out_result_r <= shift_val_s;
        end else begin
          out_result_r <= out_result_r;
        end
      end else begin
        work_r <= work_r;
        cnt_r  <= cnt_r;
      end
      out_valid_r <= (state_next_s == ST_DONE);
    end
  end

  assign in_ready   = in_ready_s;
  assign busy       = busy_s;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_rd     = out_rd_r;

endmodule
